// File: rtl/aes_cbc_pkg.sv
// Shared types and config map for the AES CBC-encrypt sequencer.
package aes_cbc_pkg;

  typedef logic [127:0] block_t;

  typedef enum logic [2:0] {
    IDLE,
    KEYLD,
    WAIT_IN,
    RUN,
    EMIT
  } state_e;

  localparam logic [3:0] CFG_KEY_HU = 4'd0;
  localparam logic [3:0] CFG_KEY_HL = 4'd1;
  localparam logic [3:0] CFG_KEY_LU = 4'd2;
  localparam logic [3:0] CFG_KEY_LL = 4'd3;
  localparam logic [3:0] CFG_IV_HU  = 4'd4;
  localparam logic [3:0] CFG_IV_HL  = 4'd5;
  localparam logic [3:0] CFG_IV_LU  = 4'd6;
  localparam logic [3:0] CFG_IV_LL  = 4'd7;
  localparam logic [3:0] CFG_SKIP   = 4'd8;

  localparam int NUM_CFG = 9;

endpackage

// File: rtl/aes_cbc_cfg_regs.sv
// Key/IV/skip register file; writes land one cycle after the strobe.
// Writes while busy or to unmapped addresses are dropped and flagged on cfg_err next cycle.
module aes_cbc_cfg_regs
  import aes_cbc_pkg::*;
#(
  parameter int SKIP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_addr,
  input  logic [31:0]       cfg_wdata,
  input  logic              busy,
  output block_t            key,
  output block_t            iv,
  output logic [SKIP_W-1:0] skip,
  output logic              cfg_err
);

  // Words 0-3 hold the key, 4-7 the IV, most significant word first.
  logic [7:0][31:0]  word_q, word_d;
  logic [SKIP_W-1:0] skip_q, skip_d;
  logic              cfg_err_q, cfg_err_d;

  always_comb begin
    word_d    = word_q;
    skip_d    = skip_q;
    cfg_err_d = 1'b0;
    if (cfg_we) begin
      if (busy || (cfg_addr >= 4'(NUM_CFG))) begin
        cfg_err_d = 1'b1;
      end else if (cfg_addr == CFG_SKIP) begin
        skip_d = cfg_wdata[SKIP_W-1:0];
      end else begin
        word_d[cfg_addr[2:0]] = cfg_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q    <= '0;
      skip_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      word_q    <= word_d;
      skip_q    <= skip_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign key     = {word_q[0], word_q[1], word_q[2], word_q[3]};
  assign iv      = {word_q[4], word_q[5], word_q[6], word_q[7]};
  assign skip    = skip_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: rtl/aes_cbc_seq.sv
// CBC-encrypt sequencer around an AES core: XOR with chain, run core, emit ciphertext.
// Latency: input handshake to out_valid = core latency + 2; holds output until out_ready, one block in flight.
module aes_cbc_seq
  import aes_cbc_pkg::*;
#(
  parameter int SKIP_W       = 16,
  parameter int CORE_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_addr,
  input  logic [31:0]       cfg_wdata,
  output logic              cfg_err,
  input  logic              go,
  output logic              busy,
  output logic              done,
  output logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      out_data,
  output logic              out_last,
  output logic [127:0]      core_key,
  output logic              core_key_load,
  output logic              core_start,
  output logic [127:0]      core_din,
  input  logic              core_done,
  input  logic [127:0]      core_dout,
  output logic [SKIP_W-1:0] blk_cnt
);

  localparam int TMO_W = (CORE_TIMEOUT > 1) ? $clog2(CORE_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((CORE_TIMEOUT > 0) ? CORE_TIMEOUT - 1 : 0);

  block_t            key, iv;
  logic [SKIP_W-1:0] skip;

  state_e            state_q, state_d;
  block_t            chain_q, chain_d;
  block_t            core_din_q, core_din_d;
  block_t            out_data_q, out_data_d;
  logic              last_q, last_d;
  logic              out_last_q, out_last_d;
  logic [SKIP_W-1:0] blk_cnt_q, blk_cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              core_start_q, core_start_d;
  logic              done_q, done_d;
  logic              abort_q, abort_d;

  aes_cbc_cfg_regs #(
    .SKIP_W (SKIP_W)
  ) u_cfg (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .busy      (busy),
    .key       (key),
    .iv        (iv),
    .skip      (skip),
    .cfg_err   (cfg_err)
  );

  always_comb begin
    state_d      = state_q;
    chain_d      = chain_q;
    core_din_d   = core_din_q;
    out_data_d   = out_data_q;
    last_d       = last_q;
    out_last_d   = out_last_q;
    blk_cnt_d    = blk_cnt_q;
    tmo_d        = tmo_q;
    core_start_d = 1'b0;
    done_d       = 1'b0;
    abort_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (go) begin
          state_d   = KEYLD;
          chain_d   = iv;
          blk_cnt_d = '0;
        end
      end
      KEYLD: state_d = WAIT_IN;
      WAIT_IN: begin
        if (in_valid) begin
          core_din_d   = in_data ^ chain_q;
          last_d       = in_last;
          core_start_d = 1'b1;
          tmo_d        = '0;
          state_d      = RUN;
        end
      end
      RUN: begin
        // A completion in the timeout cycle still wins over the abort.
        if (core_done) begin
          chain_d = core_dout;
          if (blk_cnt_q != '1) blk_cnt_d = blk_cnt_q + SKIP_W'(1);
          if (blk_cnt_q < skip) begin
            state_d = last_q ? IDLE : WAIT_IN;
            done_d  = last_q;
          end else begin
            out_data_d = core_dout;
            out_last_d = last_q;
            state_d    = EMIT;
          end
        end else if ((CORE_TIMEOUT != 0) && (tmo_q == TMO_LAST)) begin
          abort_d = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      EMIT: begin
        if (out_ready) begin
          state_d = last_q ? IDLE : WAIT_IN;
          done_d  = last_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      chain_q      <= '0;
      core_din_q   <= '0;
      out_data_q   <= '0;
      last_q       <= 1'b0;
      out_last_q   <= 1'b0;
      blk_cnt_q    <= '0;
      tmo_q        <= '0;
      core_start_q <= 1'b0;
      done_q       <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      chain_q      <= chain_d;
      core_din_q   <= core_din_d;
      out_data_q   <= out_data_d;
      last_q       <= last_d;
      out_last_q   <= out_last_d;
      blk_cnt_q    <= blk_cnt_d;
      tmo_q        <= tmo_d;
      core_start_q <= core_start_d;
      done_q       <= done_d;
      abort_q      <= abort_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign in_ready      = (state_q == WAIT_IN);
  assign out_valid     = (state_q == EMIT);
  assign core_key_load = (state_q == KEYLD);
  assign core_key      = key;
  assign core_start    = core_start_q;
  assign core_din      = core_din_q;
  assign out_data      = out_data_q;
  assign out_last      = out_last_q;
  assign blk_cnt       = blk_cnt_q;
  assign done          = done_q;
  assign abort         = abort_q;

endmodule

// File: tb/tb_aes_cbc_seq.sv
// Directed bench for aes_cbc_seq with a behavioural AES-128 core model.
module tb_aes_cbc_seq;
  import aes_cbc_pkg::*;

  logic         clk, rst;
  logic         cfg_we;
  logic [3:0]   cfg_addr;
  logic [31:0]  cfg_wdata;
  logic         cfg_err, go, busy, done, abort;
  logic         in_valid, in_ready, in_last;
  logic [127:0] in_data;
  logic         out_valid, out_ready, out_last;
  logic [127:0] out_data;
  logic [127:0] core_key, core_din, core_dout;
  logic         core_key_load, core_start, core_done;
  logic [15:0]  blk_cnt;

  aes_cbc_seq #(.SKIP_W(16), .CORE_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_err(cfg_err),
    .go(go), .busy(busy), .done(done), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .core_key(core_key), .core_key_load(core_key_load), .core_start(core_start),
    .core_din(core_din), .core_done(core_done), .core_dout(core_dout),
    .blk_cnt(blk_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  // ---------------- AES-128 reference ----------------
  logic [7:0] sbox [256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  function automatic block_t aes_enc(input block_t key, input block_t pt);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc, a0, a1, a2, a3;
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    block_t      res;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox[s[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end else begin
        s = t;
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- core model: fixed latency, optional hold ----------------
  block_t din_log [$];
  block_t core_key_lat, din_lat;
  int     pend = 0;
  int     core_lat = 1;
  logic   core_hold = 1'b0;
  logic   stray_req = 1'b0;

  initial begin
    core_done = 1'b0;
    core_dout = '0;
    forever begin
      @(negedge clk);
      core_done = 1'b0;
      if (core_key_load) core_key_lat = core_key;
      if (stray_req) begin
        core_done = 1'b1;
        core_dout = 128'hdead_beef;
        stray_req = 1'b0;
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0 && !core_hold) begin
          core_done = 1'b1;
          core_dout = aes_enc(core_key_lat, din_lat);
        end
      end
      if (core_start) begin
        din_lat = core_din;
        pend    = core_lat;
        din_log.push_back(core_din);
      end
    end
  end

  // ---------------- host tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic set_key(input block_t k);
    for (int i = 0; i < 4; i++) cfg_write(4'(i), k[127-32*i -: 32]);
  endtask

  task automatic set_iv(input block_t v);
    for (int i = 0; i < 4; i++) cfg_write(4'(4 + i), v[127-32*i -: 32]);
  endtask

  task automatic start();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic send_blk(input block_t d, input logic l);
    int n;
    in_valid = 1'b1; in_data = d; in_last = l;
    n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    chk("in_accept", 128'(in_ready), 128'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic recv_blk(output block_t d, output logic l, output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin tick(); lat++; end
    chk("out_seen", 128'(out_valid), 128'd1);
    d = out_data;
    l = out_last;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  block_t k1, k2, iv2, iv3, prev, got, exp_din;
  block_t p [4];
  block_t c [4];
  logic   gl, saw;
  int     lat, n;

  initial begin
    build_sbox();
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; go = 1'b0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_ctrl", 128'({busy, done, abort, cfg_err, in_ready, out_valid, core_start, core_key_load}), 128'd0);
    chk("rst_regs", 128'({blk_cnt, out_data, core_key} != 0), 128'd0);
    rst = 1'b0;
    tick();

    // Single block against the FIPS-197 vector.
    k1 = 128'h000102030405060708090a0b0c0d0e0f;
    set_key(k1);
    set_iv('0);
    cfg_write(CFG_SKIP, 32'd0);
    chk("skip_write_ok", 128'(cfg_err), 128'd0);
    chk("key_reg", core_key, k1);
    start();
    send_blk(128'h00112233445566778899aabbccddeeff, 1'b1);
    recv_blk(got, gl, lat);
    chk("lat_cycles", 128'(lat + 1), 128'd3);
    chk("fips_ct", got, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    chk("fips_last", 128'(gl), 128'd1);
    chk("done_pulse", 128'({done, busy}), 128'b10);
    tick();
    chk("done_once", 128'(done), 128'd0);

    // Three-block chain, SP800-38A key/IV/plaintexts.
    k2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    iv2 = 128'h000102030405060708090a0b0c0d0e0f;
    p[0] = 128'h6bc1bee22e409f96e93d7e117393172a;
    p[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    p[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    p[3] = 128'hf69f2445df4f9b17ad2b417be66c3710;
    set_key(k2);
    set_iv(iv2);
    din_log.delete();
    start();
    prev = iv2;
    for (int i = 0; i < 3; i++) begin
      c[i] = aes_enc(k2, p[i] ^ prev);
      send_blk(p[i], i == 2);
      recv_blk(got, gl, lat);
      chk("chain_ct", got, c[i]);
      chk("chain_last", 128'(gl), 128'(i == 2));
      prev = c[i];
    end
    chk("cbc_c0_kat", c[0], 128'h7649abac8119b246cee98e9b12e9197d);
    prev = iv2;
    for (int i = 0; i < 3; i++) begin
      exp_din = p[i] ^ prev;
      chk("chain_din", (din_log.size() > i) ? din_log[i] : 'x, exp_din);
      prev = c[i];
    end
    chk("chain_blk_cnt", 128'(blk_cnt), 128'd3);

    // Skip two of four; chain must still run through the skipped blocks.
    iv3 = 128'hf0e0d0c0b0a090807060504030201000;
    set_iv(iv3);
    cfg_write(CFG_SKIP, 32'd2);
    start();
    prev = iv3;
    for (int i = 0; i < 4; i++) begin
      c[i] = aes_enc(k2, p[i] ^ prev);
      prev = c[i];
    end
    for (int i = 0; i < 4; i++) begin
      send_blk(p[i], i == 3);
      if (i < 2) begin
        saw = 1'b0;
        for (int j = 0; j < 4; j++) begin tick(); saw = saw | out_valid; end
        chk("skip_suppressed", 128'(saw), 128'd0);
      end else begin
        recv_blk(got, gl, lat);
        chk("skip_ct", got, c[i]);
      end
    end
    chk("skip_blk_cnt", 128'(blk_cnt), 128'd4);

    // Skip beyond stream length: no output, done still pulses.
    cfg_write(CFG_SKIP, 32'd5);
    start();
    send_blk(p[0], 1'b0);
    send_blk(p[1], 1'b1);
    saw = 1'b0; n = 0;
    while (!done && n < 20) begin saw = saw | out_valid; tick(); n++; end
    chk("skipall_done", 128'(done), 128'd1);
    chk("skipall_noout", 128'(saw), 128'd0);

    // Backpressure: output held stable, no new input accepted.
    cfg_write(CFG_SKIP, 32'd0);
    set_iv('0);
    start();
    send_blk(p[3], 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    for (int j = 0; j < 10; j++) begin
      chk("bp_data", out_data, aes_enc(k2, p[3]));
      chk("bp_ctrl", 128'({in_ready, out_valid}), 128'b01);
      tick();
    end
    recv_blk(got, gl, lat);
    chk("bp_release_done", 128'(done), 128'd1);

    // Config write while busy is dropped; unmapped address is flagged.
    start();
    cfg_write(CFG_KEY_HU, 32'hdeadbeef);
    chk("busy_wr_err", 128'(cfg_err), 128'd1);
    tick();
    chk("busy_wr_err_pulse", 128'(cfg_err), 128'd0);
    send_blk(p[0], 1'b1);
    recv_blk(got, gl, lat);
    chk("busy_wr_key", core_key, k2);
    cfg_write(4'd12, 32'h1);
    chk("bad_addr_err", 128'(cfg_err), 128'd1);
    chk("bad_addr_key", core_key, k2);

    // Stray completion while idle.
    stray_req = 1'b1;
    tick(); tick();
    chk("stray_done", 128'({busy, out_valid, done}), 128'd0);

    // Core timeout.
    core_hold = 1'b1;
    start();
    send_blk(p[1], 1'b0);
    n = 0;
    while (!abort && n < 40) begin tick(); n++; end
    chk("tmo_cycles", 128'(n), 128'd8);
    chk("tmo_done", 128'({done, busy}), 128'b10);
    tick();
    chk("tmo_abort_once", 128'(abort), 128'd0);
    core_hold = 1'b0;

    // Asynchronous reset in EMIT.
    start();
    send_blk(p[2], 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    chk("pre_rst_emit", 128'({out_valid, blk_cnt}), 128'({1'b1, 16'd1}));
    rst = 1'b1;
    #1;
    chk("rst_async", 128'({out_valid, busy, blk_cnt}), 128'd0);
    chk("rst_key", core_key, 128'd0);
    tick();
    rst = 1'b0;
    saw = 1'b0;
    for (int j = 0; j < 4; j++) begin tick(); saw = saw | done; end
    chk("rst_no_done", 128'(saw), 128'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
